// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_t;

    typedef logic [7:0] truth_table_t;
    typedef logic [2:0] tt_idx_t;

    localparam tt_idx_t TT_LAST_IDX = 3'd7;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable settle down-counter. A load sets the count to SETTLE_CYCLES-1 so
// that tc rises in the last of SETTLE_CYCLES enabled cycles.
module tt_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("tt_settle_timer: SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    logic [7:0] cnt;

    // Reload on entry to a settle window, then count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tc = (cnt == 8'd0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: walks all 8 input combinations of a 3-input
// logic function, samples its output after a settle window, streams each
// sample and builds observed / mismatch tables against an expected table.
// Optional build macro: TT_SWEEP_ABORT_ON_MISMATCH_EN ends the sweep at the
// first accepted sample that disagrees with the expected table.
//
// state | meaning
// IDLE  | accepts configuration and start
// APPLY | drives idx onto in1..in3 and waits for the settle timer
// EMIT  | presents the captured sample until smp_ready
// DONE  | one-cycle done pulse, pass is valid
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_table,
    input  logic       start,
    output logic       busy,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       fn_out,
    output logic       smp_valid,
    input  logic       smp_ready,
    output logic [2:0] smp_idx,
    output logic       smp_bit,
    output logic       smp_err,
    output logic       done,
    output logic [7:0] obs_table,
    output logic [7:0] mismatch,
    output logic       pass
);

    sweep_state_t state, state_nxt;
    truth_table_t exp_table, obs_q, mis_q;
    tt_idx_t      idx;
    logic         pass_q, smp_bit_q, smp_err_q;
    logic         settle_tc, settle_load, sweep_end;

`ifdef TT_SWEEP_ABORT_ON_MISMATCH_EN
    assign sweep_end = (idx == TT_LAST_IDX) || smp_err_q;
`else
    assign sweep_end = (idx == TT_LAST_IDX);
`endif

    assign settle_load = ((state == ST_IDLE) && start) ||
                         ((state == ST_EMIT) && smp_ready && !sweep_end);

    tt_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (settle_load),
        .en   (state == ST_APPLY),
        .tc   (settle_tc)
    );

    // State register plus the table/index datapath it sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            exp_table <= '0;
            obs_q     <= '0;
            mis_q     <= '0;
            idx       <= '0;
            pass_q    <= 1'b0;
            smp_bit_q <= 1'b0;
            smp_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) exp_table <= cfg_table;
                    if (start) begin
                        idx    <= '0;
                        obs_q  <= '0;
                        mis_q  <= '0;
                        pass_q <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (settle_tc) begin
                        obs_q[idx] <= fn_out;
                        mis_q[idx] <= fn_out ^ exp_table[idx];
                        smp_bit_q  <= fn_out;
                        smp_err_q  <= fn_out ^ exp_table[idx];
                    end
                end
                ST_EMIT: begin
                    // mis_q already holds this sample's bit, so pass is
                    // final here and visible throughout DONE.
                    if (smp_ready) begin
                        if (sweep_end) pass_q <= ~|mis_q;
                        else           idx    <= idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        state_nxt         = state;
        cfg_ready         = 1'b0;
        smp_valid         = 1'b0;
        done              = 1'b0;
        {in1, in2, in3}   = 3'b000;
        case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (start) state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                {in1, in2, in3} = idx;
                if (settle_tc) state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                {in1, in2, in3} = idx;
                smp_valid       = 1'b1;
                if (smp_ready) state_nxt = sweep_end ? ST_DONE : ST_APPLY;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy      = ~cfg_ready;
    assign smp_idx   = idx;
    assign smp_bit   = smp_bit_q;
    assign smp_err   = smp_err_q;
    assign obs_table = obs_q;
    assign mismatch  = mis_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: a truth-table function model drives fn_out and a
// per-sweep reference computes samples, final tables and done timing.
module tb_tt_sweep_ctrl;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_table = 8'h00;
    logic       start = 1'b0;
    logic       busy;
    logic       in1, in2, in3;
    logic       fn_out;
    logic       smp_valid;
    logic       smp_ready = 1'b1;
    logic [2:0] smp_idx;
    logic       smp_bit, smp_err;
    logic       done;
    logic [7:0] obs_table, mismatch;
    logic       pass;

    logic [7:0] fn_code = 8'hDB;
    logic [7:0] cur_tbl = 8'h00;
    int checks = 0;
    int failures = 0;

    assign fn_out = fn_code[{in1, in2, in3}];

    always #5 clk = ~clk;

    tt_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_table(cfg_table), .start(start), .busy(busy),
        .in1(in1), .in2(in2), .in3(in3), .fn_out(fn_out),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_idx(smp_idx),
        .smp_bit(smp_bit), .smp_err(smp_err), .done(done),
        .obs_table(obs_table), .mismatch(mismatch), .pass(pass)
    );

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cfg_ready, busy, smp_valid, done, pass} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl got cfg_ready/busy/valid/done/pass=%b want 10000",
                     {cfg_ready, busy, smp_valid, done, pass});
        end
        checks++;
        if ({in1, in2, in3, smp_idx} !== 6'd0 || obs_table !== 8'h00 || mismatch !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got pins=%b idx=%0d obs=%h mis=%h want 0",
                     {in1, in2, in3}, smp_idx, obs_table, mismatch);
        end
        rst = 1'b0;
        cur_tbl = 8'h00;
    endtask

    // One complete sweep with optional EMIT stall and a mid-sweep start/cfg poke.
    task automatic run_sweep(input string name, input bit do_cfg, input logic [7:0] tbl,
                             input logic [7:0] code, input int stall_idx,
                             input int stall_len, input bit poke);
        int n, cyc, ns, stall_left, done_e;
        bit seen_done;
        logic [7:0] mask, obs_e, mis_e;
        bit pass_e;
        if (do_cfg) cur_tbl = tbl;
        fn_code = code;
        n = 8;
`ifdef TT_SWEEP_ABORT_ON_MISMATCH_EN
        for (int i = 7; i >= 0; i--) if (code[i] != cur_tbl[i]) n = i + 1;
`endif
        mask   = (n == 8) ? 8'hFF : 8'((1 << n) - 1);
        obs_e  = code & mask;
        mis_e  = (code ^ cur_tbl) & mask;
        pass_e = (mis_e == 8'h00);
        done_e = n * (S + 1) + 1 + ((stall_idx < n) ? stall_len : 0);

        @(posedge clk); #1;
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_before got cfg_ready=%b busy=%b want 1 0", name, cfg_ready, busy);
        end
        start = 1'b1; cfg_valid = do_cfg; cfg_table = tbl; smp_ready = 1'b1;
        cyc = 0; ns = 0; stall_left = stall_len; seen_done = 1'b0;
        while (!seen_done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0; cfg_valid = 1'b0;
            if (poke && cyc == 10) begin
                start = 1'b1; cfg_valid = 1'b1; cfg_table = ~cur_tbl;
            end
            checks++;
            if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s busy cyc=%0d got busy=%b cfg_ready=%b want 1 0",
                         name, cyc, busy, cfg_ready);
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
            end else if (smp_valid === 1'b1) begin
                checks++;
                if (ns >= n || smp_idx !== 3'(ns) || {in1, in2, in3} !== 3'(ns) ||
                    smp_bit !== code[ns % 8] || smp_err !== (code[ns % 8] ^ cur_tbl[ns % 8])) begin
                    failures++;
                    $display("FAIL %s sample%0d got idx=%0d pins=%b bit=%b err=%b want idx=%0d bit=%b err=%b (n=%0d)",
                             name, ns, smp_idx, {in1, in2, in3}, smp_bit, smp_err, ns % 8,
                             code[ns % 8], code[ns % 8] ^ cur_tbl[ns % 8], n);
                end
                if (ns == stall_idx && stall_left > 0) begin
                    smp_ready = 1'b0;
                    stall_left--;
                end else begin
                    smp_ready = 1'b1;
                    ns++;
                end
            end
        end
        smp_ready = 1'b1;
        checks++;
        if (!seen_done) begin
            failures++;
            $display("FAIL %s done_timeout got no done in %0d cycles want cycle %0d", name, cyc, done_e);
        end else begin
            checks++;
            if (cyc != done_e || ns != n) begin
                failures++;
                $display("FAIL %s done_cycle got cycle=%0d samples=%0d want cycle=%0d samples=%0d",
                         name, cyc, ns, done_e, n);
            end
            checks++;
            if (obs_table !== obs_e || mismatch !== mis_e || pass !== pass_e) begin
                failures++;
                $display("FAIL %s result got obs=%h mis=%h pass=%b want obs=%h mis=%h pass=%b",
                         name, obs_table, mismatch, pass, obs_e, mis_e, pass_e);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || obs_table !== obs_e ||
            mismatch !== mis_e || pass !== pass_e) begin
            failures++;
            $display("FAIL %s after_done got done=%b busy=%b obs=%h mis=%h pass=%b want 0 0 %h %h %b",
                     name, done, busy, obs_table, mismatch, pass, obs_e, mis_e, pass_e);
        end
    endtask

    task automatic test_nominal;
        run_sweep("nominal_db", 1'b1, 8'hDB, 8'hDB, 9, 0, 1'b0);
    endtask

    task automatic test_mismatch;
        run_sweep("db_vs_da", 1'b1, 8'hDB, 8'hDA, 9, 0, 1'b0);
    endtask

    task automatic test_stall;
        run_sweep("stall_idx3", 1'b1, 8'hDB, 8'hDB, 3, 5, 1'b0);
    endtask

    task automatic test_cfg_start_poke;
        run_sweep("cfg96_poke", 1'b1, 8'h96, 8'hDB, 9, 0, 1'b1);
    endtask

    task automatic test_abort_case;
        run_sweep("db_vs_ff", 1'b1, 8'hDB, 8'hFF, 9, 0, 1'b0);
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit hit;
        cur_tbl = 8'hDB;
        fn_code = 8'hDB;
        @(posedge clk); #1;
        start = 1'b1; cfg_valid = 1'b1; cfg_table = 8'hDB; smp_ready = 1'b1;
        hit = 1'b0;
        for (cyc = 0; cyc < 200 && !hit; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0; cfg_valid = 1'b0;
            if (busy === 1'b1 && smp_valid === 1'b0 && done === 1'b0 && {in1, in2, in3} === 3'd5)
                hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rst_mid reach_apply5 got no APPLY idx5 within %0d cycles want reached", cyc);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cur_tbl = 8'h00;
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || {in1, in2, in3} !== 3'b000 ||
            smp_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid state got busy=%b cfg_ready=%b pins=%b valid=%b done=%b want 0 1 000 0 0",
                     busy, cfg_ready, {in1, in2, in3}, smp_valid, done);
        end
        hit = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy !== 1'b0) hit = 1'b1;
        end
        checks++;
        if (hit) begin
            failures++;
            $display("FAIL rst_mid quiet got done/busy activity after reset want none");
        end
        run_sweep("post_rst_tbl0", 1'b0, 8'h00, 8'hDB, 9, 0, 1'b0);
    endtask

    task automatic test_random;
        logic [7:0] t, c;
        for (int r = 0; r < 6; r++) begin
            t = 8'($urandom);
            c = ($urandom_range(0, 1) == 0) ? t : 8'($urandom);
            run_sweep("random", 1'b1, t, c, $urandom_range(0, 7), $urandom_range(0, 4), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mismatch();
        test_stall();
        test_reset_mid();
        test_cfg_start_poke();
        test_abort_case();
        test_random();
        test_nominal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
